// File: rtl/ir_pkg.sv
// Shared NEC infrared definitions for ir_encoder and ir_decoder.
// Holds the state enum, NEC unit counts and the 32-bit frame-word builder.
package ir_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP,
    REP_MARK,
    REP_SPACE,
    REP_STOP
  } ir_state_t;

  localparam int LEAD_MARK_UNITS  = 16;
  localparam int LEAD_SPACE_UNITS = 8;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int REP_SPACE_UNITS  = 4;
  localparam int FRAME_UNITS      = 192;

  // NEC word as transmitted LSB first: address leaves the LED first.
  function automatic logic [31:0] build_frame_word(input logic [7:0] address,
                                                   input logic [7:0] command);
    return {~command, command, ~address, address};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier square wave for IR marks: high for the first half of each period.
// A synchronous restart makes the following cycle the start of a fresh period.
module ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CARRIER_DIV / 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign carrier = (count < HALF);

endmodule

// File: rtl/ir_encoder.sv
// NEC-format IR transmitter: serialises {~cmd, cmd, ~addr, addr} with a carrier.
// Define IR_REPEAT_EN to add the 192-unit frame gap and key-held repeat codes.
module ir_encoder
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES = 28125,
  parameter int CARRIER_DIV = 1316
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_address,
  input  logic [7:0] i_command,
  input  logic       i_hold,
  output logic       o_ir_led,
  output logic       o_envelope,
  output logic       o_busy,
  output logic       o_done
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

  ir_state_t   state;
  logic [UW-1:0] unit_cnt;
  logic [3:0]  seg_cnt;
  logic [3:0]  seg_last;
  logic [4:0]  bit_idx;
  logic [31:0] word;
  logic        envelope;
  logic        busy;
  logic        done;
  logic        carrier;
  logic        cur_bit;
  logic        unit_end;
  logic        seg_end;
  logic        leave;
  logic        restart;

  assign cur_bit  = word[bit_idx];
  assign unit_end = (unit_cnt == UNIT_LAST);
  assign seg_end  = unit_end && (seg_cnt == seg_last);

  // Length of the current segment in units, minus one.
  always_comb begin
    seg_last = 4'd0;
    case (state)
      LEAD_MARK, REP_MARK: seg_last = 4'(LEAD_MARK_UNITS - 1);
      LEAD_SPACE:          seg_last = 4'(LEAD_SPACE_UNITS - 1);
      BIT_SPACE:           seg_last = cur_bit ? 4'(ONE_SPACE_UNITS - 1)
                                              : 4'(ZERO_SPACE_UNITS - 1);
      REP_SPACE:           seg_last = 4'(REP_SPACE_UNITS - 1);
      default:             seg_last = 4'd0;
    endcase
  end

`ifdef IR_REPEAT_EN
  logic [7:0] frame_units;
  logic       gap_end;

  // The gap is timed from the start of the lead or repeat mark, not from its own start.
  assign gap_end = (state == GAP) && unit_end && (frame_units == 8'(FRAME_UNITS - 1));
  assign leave   = (state == GAP) ? gap_end : seg_end;
  assign restart = (state == IDLE && i_start) ||
                   (seg_end && (state == LEAD_SPACE || state == BIT_SPACE ||
                                state == REP_SPACE)) ||
                   (gap_end && i_hold);
`else
  logic unused_hold;

  assign unused_hold = i_hold;
  assign leave       = seg_end;
  assign restart     = (state == IDLE && i_start) ||
                       (seg_end && (state == LEAD_SPACE || state == BIT_SPACE));
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      unit_cnt <= '0;
      seg_cnt  <= '0;
      bit_idx  <= '0;
      word     <= '0;
      envelope <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef IR_REPEAT_EN
      frame_units <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        unit_cnt <= '0;
        seg_cnt  <= '0;
        if (i_start) begin
          word     <= build_frame_word(i_address, i_command);
          bit_idx  <= '0;
          state    <= LEAD_MARK;
          envelope <= 1'b1;
          busy     <= 1'b1;
`ifdef IR_REPEAT_EN
          frame_units <= '0;
`endif
        end
      end else begin
        unit_cnt <= unit_end ? '0 : unit_cnt + UW'(1);
        if (unit_end) begin
          seg_cnt <= seg_end ? 4'd0 : seg_cnt + 4'd1;
`ifdef IR_REPEAT_EN
          frame_units <= frame_units + 8'd1;
`endif
        end
        if (leave) begin
          case (state)
            LEAD_MARK: begin
              state    <= LEAD_SPACE;
              envelope <= 1'b0;
            end
            LEAD_SPACE: begin
              state    <= BIT_MARK;
              envelope <= 1'b1;
            end
            BIT_MARK: begin
              state    <= BIT_SPACE;
              envelope <= 1'b0;
            end
            BIT_SPACE: begin
              envelope <= 1'b1;
              if (bit_idx == 5'd31) begin
                state <= STOP_MARK;
              end else begin
                bit_idx <= bit_idx + 5'd1;
                state   <= BIT_MARK;
              end
            end
`ifdef IR_REPEAT_EN
            STOP_MARK, REP_STOP: begin
              state    <= GAP;
              envelope <= 1'b0;
            end
            GAP: begin
              if (i_hold) begin
                state       <= REP_MARK;
                envelope    <= 1'b1;
                frame_units <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
            REP_MARK: begin
              state    <= REP_SPACE;
              envelope <= 1'b0;
            end
            REP_SPACE: begin
              state    <= REP_STOP;
              envelope <= 1'b1;
            end
`else
            STOP_MARK: begin
              state    <= IDLE;
              envelope <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
`endif
            default: begin
              state    <= IDLE;
              envelope <= 1'b0;
              busy     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .clk    (i_clk),
    .reset  (i_reset),
    .restart(restart),
    .carrier(carrier)
  );

  assign o_envelope = envelope;
  assign o_busy     = busy;
  assign o_done     = done;
  assign o_ir_led   = envelope & carrier;

endmodule
